// File: rtl/oct5_disp_scan.sv
// Fetches five octal digits from the storage register into a shadow copy and
// scans them onto a 5-digit common-anode display. Optional LEADING_ZERO_BLANK_EN.
module oct5_disp_scan #(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned DIV_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic       rd_en,
    input  logic [2:0] data_i_0,
    input  logic [2:0] data_i_1,
    input  logic [2:0] data_i_2,
    input  logic [2:0] data_i_3,
    input  logic [2:0] data_i_4,
    output logic       busy,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ1 = 2'd1;
    localparam logic [1:0] ST_REQ2 = 2'd2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    logic [1:0]       state_q, state_d;
    logic             rd_en_q, busy_q, fetch_d;
    logic [4:0][2:0]  shadow_q, shadow_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             div_wrap_c;
    logic [2:0]       digit_c;
    logic             blank_c;
    logic [4:0]       lead_zero_c;

    function automatic logic [6:0] seg_decode(input logic [2:0] d);
        case (d)
            3'd0:    seg_decode = 7'b1000000;
            3'd1:    seg_decode = 7'b1111001;
            3'd2:    seg_decode = 7'b0100100;
            3'd3:    seg_decode = 7'b0110000;
            3'd4:    seg_decode = 7'b0011001;
            3'd5:    seg_decode = 7'b0010010;
            3'd6:    seg_decode = 7'b0000010;
            default: seg_decode = 7'b1111000;
        endcase
    endfunction

    // Fetch FSM: two-cycle read window, capture on leaving REQ2.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_REQ1;
            ST_REQ1: state_d = ST_REQ2;
            ST_REQ2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        fetch_d = (state_d == ST_REQ1) || (state_d == ST_REQ2);
        if (state_q == ST_REQ2) begin
            shadow_d = {data_i_4, data_i_3, data_i_2, data_i_1, data_i_0};
        end
    end

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero_c = {shadow_q[4] == 3'd0,
                       shadow_q[4:3] == 6'd0,
                       shadow_q[4:2] == 9'd0,
                       shadow_q[4:1] == 12'd0,
                       1'b0};
`else
        lead_zero_c = 5'b00000;
`endif
    end

    // Scan engine: divider, digit index and registered display drive.
    always_comb begin
        div_wrap_c = (div_q == DIV_LAST);
        div_d      = div_wrap_c ? '0 : div_q + DIV_W'(1);
        idx_d      = idx_q;
        if (div_wrap_c) begin
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
        digit_c = 3'd0;
        blank_c = 1'b0;
        case (idx_q)
            3'd0:    begin digit_c = shadow_q[0]; blank_c = lead_zero_c[0]; end
            3'd1:    begin digit_c = shadow_q[1]; blank_c = lead_zero_c[1]; end
            3'd2:    begin digit_c = shadow_q[2]; blank_c = lead_zero_c[2]; end
            3'd3:    begin digit_c = shadow_q[3]; blank_c = lead_zero_c[3]; end
            3'd4:    begin digit_c = shadow_q[4]; blank_c = lead_zero_c[4]; end
            default: begin digit_c = 3'd0;        blank_c = 1'b0;           end
        endcase
        an_d  = ~(5'b00001 << idx_q);
        seg_d = blank_c ? SEG_BLANK : seg_decode(digit_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
            div_q    <= '0;
            idx_q    <= 3'd0;
            an_q     <= 5'b11110;
            seg_q    <= 7'b1000000;
        end else begin
            state_q  <= state_d;
            rd_en_q  <= fetch_d;
            busy_q   <= fetch_d;
            shadow_q <= shadow_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign rd_en = rd_en_q;
    assign busy  = busy_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_oct5_disp_scan.sv
// Directed self-checking bench for oct5_disp_scan: instance a uses CLK_DIV=4,
// instance b uses CLK_DIV=1 for fast whole-display sweeps.
module tb_oct5_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] d0, d1, d2, d3, d4;
    logic       rd_en_a, busy_a, dp_a, rd_en_b, busy_b, dp_b;
    logic [4:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tab [8];

    always #5 clk = ~clk;

    oct5_disp_scan #(.CLK_DIV(4), .DIV_W(3)) dut_a (
        .clk(clk), .rst(rst), .load(load), .rd_en(rd_en_a),
        .data_i_0(d0), .data_i_1(d1), .data_i_2(d2), .data_i_3(d3), .data_i_4(d4),
        .busy(busy_a), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    oct5_disp_scan #(.CLK_DIV(1), .DIV_W(1)) dut_b (
        .clk(clk), .rst(rst), .load(load), .rd_en(rd_en_b),
        .data_i_0(d0), .data_i_1(d1), .data_i_2(d2), .data_i_3(d3), .data_i_4(d4),
        .busy(busy_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        load = 1'b1;
        repeat (3) tick();
        checks++;
        if (rd_en_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_fsm: rd_en=%b busy=%b, want 0 0", rd_en_a, busy_a);
        end
        checks++;
        if (an_a !== 5'b11110 || seg_a !== 7'b1000000 || dp_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_disp: an=%b seg=%b dp=%b, want 11110 1000000 1", an_a, seg_a, dp_a);
        end
        checks++;
        if (rd_en_b !== 1'b0 || an_b !== 5'b11110 || seg_b !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_b: rd_en=%b an=%b seg=%b", rd_en_b, an_b, seg_b);
        end
        load = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_fetch_scan();
        logic [2:0] dig [5];
        logic [4:0] prev;
        logic [4:0] exp_an;
        bit found;
        dig = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        d0 = dig[0]; d1 = dig[1]; d2 = dig[2]; d3 = dig[3]; d4 = dig[4];
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_en_a !== (i < 2) || busy_a !== (i < 2)) begin
                failures++;
                $display("FAIL fetch_window[%0d]: rd_en=%b busy=%b, want %b", i, rd_en_a, busy_a, i < 2);
            end
            if (i < 2) tick();
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = an_a;
            tick();
            if (an_a == 5'b11110 && prev != 5'b11110) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL scan_sync: slot 0 start not seen, an=%b", an_a);
        end
        for (int k = 0; k < 5; k++) begin
            exp_an = ~(5'b00001 << k);
            checks++;
            if (an_a !== exp_an || seg_a !== seg_tab[dig[k]]) begin
                failures++;
                $display("FAIL scan_slot%0d: an=%b seg=%b, want %b %b", k, an_a, seg_a, exp_an, seg_tab[dig[k]]);
            end
            repeat (4) tick();
        end
        checks++;
        if (an_a !== 5'b11110 || seg_a !== 7'b0110000) begin
            failures++;
            $display("FAIL scan_wrap: an=%b seg=%b, want 11110 0110000", an_a, seg_a);
        end
    endtask

    task automatic test_busy_lockout();
        int cnt = 0;
        load = 1'b1;
        tick(); cnt += int'(rd_en_a);
        tick(); cnt += int'(rd_en_a);
        load = 1'b0;
        tick(); cnt += int'(rd_en_a);
        tick(); cnt += int'(rd_en_a);
        checks++;
        if (cnt != 2) begin
            failures++;
            $display("FAIL lockout_count: rd_en high %0d cycles, want 2", cnt);
        end
        checks++;
        if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
            failures++;
            $display("FAIL lockout_idle: busy=%b rd_en=%b, want 0 0", busy_a, rd_en_a);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit seen = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        d0 = 3'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (rd_en_b !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL midrst_req1: rd_en=%b busy=%b, want 1 1", rd_en_b, busy_b);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (rd_en_b !== 1'b0 || busy_b !== 1'b0 || rd_en_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort: rd_en=%b%b busy=%b%b, want 00 00", rd_en_a, rd_en_b, busy_a, busy_b);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (an_b == 5'b11110 && !seen) begin
                seen = 1'b1;
                checks++;
                if (seg_b !== 7'b1000000) begin
                    failures++;
                    $display("FAIL midrst_shadow: seg=%b, want 1000000", seg_b);
                end
            end
        end
        checks++;
        if (!seen || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after: slot0 seen=%b busy=%b, want 1 0", seen, busy_b);
        end
    endtask

    task automatic test_lzb();
        logic [6:0] exp_seg [5];
        logic [4:0] seen = 5'b0;
        int k;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = '{7'b0100100, 7'b1111001, 7'b1111111, 7'b1111111, 7'b1111111};
`else
        exp_seg = '{7'b0100100, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
        d0 = 3'd2; d1 = 3'd1; d2 = 3'd0; d3 = 3'd0; d4 = 3'd0;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            k = -1;
            for (int j = 0; j < 5; j++) if (an_b == ~(5'b00001 << j)) k = j;
            checks++;
            if (k < 0) begin
                failures++;
                $display("FAIL lzb_an: an=%b not one-hot low", an_b);
            end else begin
                seen[k] = 1'b1;
                if (seg_b !== exp_seg[k]) begin
                    failures++;
                    $display("FAIL lzb_slot%0d: seg=%b, want %b", k, seg_b, exp_seg[k]);
                end
            end
        end
        checks++;
        if (seen !== 5'b11111) begin
            failures++;
            $display("FAIL lzb_cover: slots seen=%b, want 11111", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] dig [5];
        int k;
        d0 = 3'd1; d1 = 3'd2; d2 = 3'd3; d3 = 3'd4; d4 = 3'd5;
        load = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (rd_en_b !== ((i % 3) != 2)) begin
                failures++;
                $display("FAIL b2b_rden[%0d]: rd_en=%b, want %b", i, rd_en_b, (i % 3) != 2);
            end
            if (i == 2) begin
                d0 = 3'd6; d1 = 3'd7; d2 = 3'd0; d3 = 3'd1; d4 = 3'd2;
            end
            if (i == 5) begin
                d0 = 3'd7; d1 = 3'd0; d2 = 3'd5; d3 = 3'd0; d4 = 3'd3;
            end
        end
        load = 1'b0;
        dig = '{3'd7, 3'd0, 3'd5, 3'd0, 3'd3};
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            k = -1;
            for (int j = 0; j < 5; j++) if (an_b == ~(5'b00001 << j)) k = j;
            checks++;
            if (k < 0) begin
                failures++;
                $display("FAIL b2b_an: an=%b not one-hot low", an_b);
            end else if (seg_b !== seg_tab[dig[k]]) begin
                failures++;
                $display("FAIL b2b_slot%0d: seg=%b, want %b", k, seg_b, seg_tab[dig[k]]);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        rst = 1'b0;
        load = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        #2;
        test_reset();
        test_fetch_scan();
        test_busy_lockout();
        test_reset_mid_fetch();
        test_lzb();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oct5_disp_scan.md
Name: oct5_disp_scan

Overview:
- Reader-side companion to the 5-digit octal storage register.
- On a load request, pulses the register's read enable and captures the 5 octal digits into a shadow copy.
- Continuously time-multiplexes the shadow digits onto a 5-digit common-anode 7-segment display.
- Sits between the register's data_o_0..4 / read_en pins and the board display pins.

Parameters:
- CLK_DIV, 100000, clk cycles per digit slot (>=1).
- DIV_W, 17, divider counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- load  in  1  request to fetch a new value from the register; level-sampled.
- rd_en  out  1  read enable to the register's read_en.
- data_i_0..data_i_4  in  3 each  digits from the register's data_o_0..4; data_i_0 is the least-significant digit.
- busy  out  1  high while a fetch is in progress.
- an  out  5  digit enables, active-low, one-hot; an[k] selects digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- All state updates on the rising clk edge. rst=0 at an edge forces reset regardless of other inputs.
- Reset values:
  - Fetch FSM = IDLE; rd_en=0; busy=0.
  - Shadow digits = 0; digit index = 0; divider = 0.
  - an=5'b11110; seg=7'b1000000; dp=1.
- Fetch FSM, states IDLE, REQ1, REQ2:
  - IDLE: load=1 -> REQ1; otherwise stay.
  - REQ1 -> REQ2 unconditionally.
  - REQ2 -> IDLE unconditionally; on this edge the shadow digits capture data_i_0..4.
  - rd_en and busy are registered: high exactly while the state is REQ1 or REQ2, i.e. two cycles per fetch.
  - The two-cycle window lets the register's combinational read path settle before capture.
  - load is ignored while busy=1.
  - load held high re-fetches back-to-back: IDLE occupies 1 cycle between fetches.
- Scan engine:
  - Divider counts 0..CLK_DIV-1, then wraps to 0.
  - On the wrap edge the digit index advances 0->1->2->3->4->0.
  - an and seg are registered from the current index and shadow, one cycle behind the index.
  - With CLK_DIV=1 the index advances every cycle.
- Decode (seg, active-low):
  - 0 -> 1000000
  - 1 -> 1111001
  - 2 -> 0100100
  - 3 -> 0110000
  - 4 -> 0011001
  - 5 -> 0010010
  - 6 -> 0000010
  - 7 -> 1111000
- Simultaneous events:
  - A shadow capture on the same edge as an index advance: the new digit value appears on seg at the next output register update.
  - Capture does not reset the divider or the index.
- Reset mid-fetch: FSM returns to IDLE; rd_en and busy are 0 after that edge; the shadow keeps its reset value 0 (no partial capture).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k in 1..4 is blanked (seg=7'b1111111) when digit k and every higher digit are 0.
  - Digit 0 is never blanked.
  - an scanning is unchanged.
- Undefined: every digit is always decoded, including leading zeros.

Test Plan:
- Reset: rst=0 for 3 cycles with load=1 -> rd_en=0, busy=0, an=11110, seg=1000000, dp=1.
- Fetch and scan: CLK_DIV=4, data_i_4..0=7,6,5,4,3, one-cycle load pulse -> rd_en=1 and busy=1 for exactly 2 cycles. Then the display shows:
  - an=11110 with seg=0110000
  - after 4 cycles, an=11101 with seg=0011001
  - continuing through digits 2, 3, 4 (5, 6, 7)
  - an=01111 with seg=1111000
  - wraps back to an=11110 20 cycles after the first slot.
- Busy lockout: load pulses again in REQ1 and REQ2 -> no extra rd_en cycles; total rd_en high = 2 cycles; then IDLE.
- Reset mid-fetch: rst=0 in REQ1 with data_i_0=5 -> after that edge rd_en=0, busy=0; digit 0 still decodes 1000000.
- Leading-zero blank: value 00012, CLK_DIV=1 -> with LEADING_ZERO_BLANK_EN, slots 2, 3, 4 show seg=1111111 and slots 0/1 show 0100100/1111001. Without the macro, slots 2..4 show 1000000.
- Continuous load=1: rd_en pattern is 1,1,0 repeating (2 high, 1 low); shadow tracks data_i changes applied between fetches.
